// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table predictor.
package bp_pkg;

   // PC bits [1:0] are always zero for aligned instructions, so indexing starts at bit 2.
   localparam int BP_IDX_LSB = 2;

   // Widest counter the table supports; ctr_next works at this width.
   localparam int BP_CTR_MAX_W = 4;

   // Number of table entries for a given index width.
   function automatic int bp_entries(input int idx_bits);
      return 1 << idx_bits;
   endfunction

   // Saturating counter step. Narrower counters are zero-extended by the
   // caller and pass their own maximum value.
   function automatic logic [BP_CTR_MAX_W-1:0] ctr_next(
      input logic [BP_CTR_MAX_W-1:0] ctr,
      input logic                    taken,
      input logic [BP_CTR_MAX_W-1:0] ctr_max
   );
      if (taken) begin
         return (ctr == ctr_max) ? ctr : ctr + 4'd1;
      end
      return (ctr == 4'd0) ? ctr : ctr - 4'd1;
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One table entry: CTR_BITS-wide saturating up/down counter with
// synchronous active-low reset to CTR_INIT.
module bp_sat_counter
   import bp_pkg::*;
#(
   parameter int CTR_BITS = 2,
   parameter int CTR_INIT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                taken,
   output logic [CTR_BITS-1:0] ctr
);

   localparam logic [BP_CTR_MAX_W-1:0] CTR_MAX = BP_CTR_MAX_W'((1 << CTR_BITS) - 1);
   localparam logic [CTR_BITS-1:0]     CTR_RST = CTR_BITS'(CTR_INIT);

   // Reset wins over an update arriving on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctr <= CTR_RST;
      end else if (en) begin
         ctr <= CTR_BITS'(ctr_next(BP_CTR_MAX_W'(ctr), taken, CTR_MAX));
      end
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table: 2^IDX_BITS saturating counters indexed by PC.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor_bht
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int CTR_BITS = 2,
   parameter int CTR_INIT = 1,
   parameter int GHR_BITS = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_decode_sig,
   input  logic [31:0] in_addr,
   input  logic [31:0] offset,
   output logic [31:0] branch_addr,
   output logic        prediction,
   input  logic        update_valid,
   input  logic [31:0] update_addr,
   input  logic        actual_branch_decision
);

   localparam int ENTRIES = bp_entries(IDX_BITS);
   localparam int IDX_MSB = IDX_BITS + BP_IDX_LSB - 1;

   logic [CTR_BITS-1:0] ctr_q [ENTRIES];
   logic [IDX_BITS-1:0] pidx;
   logic [IDX_BITS-1:0] uidx;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{in_addr[31:IDX_MSB+1], in_addr[BP_IDX_LSB-1:0],
                               update_addr[31:IDX_MSB+1], update_addr[BP_IDX_LSB-1:0]};

`ifdef BP_GSHARE_EN
   logic [GHR_BITS-1:0] ghr;

   assign pidx = in_addr[IDX_MSB:BP_IDX_LSB] ^ IDX_BITS'(ghr);
   assign uidx = update_addr[IDX_MSB:BP_IDX_LSB] ^ IDX_BITS'(ghr);

   // Shift the resolved outcome into the history; the table update on the
   // same edge still uses the old history for its index.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ghr <= '0;
      end else if (update_valid) begin
         ghr <= GHR_BITS'({ghr, actual_branch_decision});
      end
   end
`else
   assign pidx = in_addr[IDX_MSB:BP_IDX_LSB];
   assign uidx = update_addr[IDX_MSB:BP_IDX_LSB];
`endif

   for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
      bp_sat_counter #(
         .CTR_BITS (CTR_BITS),
         .CTR_INIT (CTR_INIT)
      ) u_ctr (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (update_valid && (uidx == IDX_BITS'(i))),
         .taken (actual_branch_decision),
         .ctr   (ctr_q[i])
      );
   end

   // Read-before-write: the table read sees the value registered before this edge.
   assign prediction  = branch_decode_sig & ctr_q[pidx][CTR_BITS-1];
   assign branch_addr = in_addr + offset;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht in its default (PC-indexed) build.
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        branch_decode_sig;
   logic [31:0] in_addr;
   logic [31:0] offset;
   logic [31:0] branch_addr;
   logic        prediction;
   logic        update_valid;
   logic [31:0] update_addr;
   logic        actual_branch_decision;

   typedef struct {
      string       name;
      logic        pred;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   branch_predictor_bht dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .branch_decode_sig      (branch_decode_sig),
      .in_addr                (in_addr),
      .offset                 (offset),
      .branch_addr            (branch_addr),
      .prediction             (prediction),
      .update_valid           (update_valid),
      .update_addr            (update_addr),
      .actual_branch_decision (actual_branch_decision)
   );

   always #5 clk = ~clk;

   // Monitor: on every falling edge, compare a presented prediction with the
   // oldest expectation, or check the output is quiet when decode is idle.
   always @(negedge clk) begin
      exp_t e;
      if (branch_decode_sig === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow: prediction presented with no expectation queued");
         end else begin
            e = exp_q.pop_front();
            if (prediction !== e.pred || branch_addr !== e.addr) begin
               failures++;
               $display("FAIL %s: got pred=%0b addr=%08h, want pred=%0b addr=%08h",
                        e.name, prediction, branch_addr, e.pred, e.addr);
            end
         end
      end else begin
         checks++;
         if (prediction !== 1'b0) begin
            failures++;
            $display("FAIL idle_pred: got %0b with branch_decode_sig low, want 0", prediction);
         end
      end
   end

   task automatic step(input logic rst, input logic dec, input logic [31:0] a,
                       input logic [31:0] off, input logic [31:0] ea, input logic ep,
                       input string nm, input logic upd, input logic [31:0] ua,
                       input logic tk);
      @(posedge clk);
      #1;
      rst_n                  = rst;
      branch_decode_sig      = dec;
      in_addr                = a;
      offset                 = off;
      update_valid           = upd;
      update_addr            = ua;
      actual_branch_decision = tk;
      if (dec) exp_q.push_back('{nm, ep, ea});
   endtask

   task automatic upd(input logic [31:0] ua, input logic tk);
      step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "", 1'b1, ua, tk);
   endtask

   task automatic pred(input logic [31:0] a, input logic [31:0] off,
                       input logic [31:0] ea, input logic ep, input string nm);
      step(1'b1, 1'b1, a, off, ea, ep, nm, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "", 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; branch_decode_sig = 1'b0; in_addr = '0; offset = '0;
      update_valid = 1'b0; update_addr = '0; actual_branch_decision = 1'b0;
      step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "", 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "", 1'b0, 32'h0, 1'b0);

      // After reset every counter is 1 (weakly not-taken).
      pred(32'h100, 32'hFFFF_FFF0, 32'h0000_00F0, 1'b0, "reset_pred");

      // Entry 1: 1 -> 2 -> 3; entry 2 untouched.
      upd(32'h104, 1'b1);
      upd(32'h104, 1'b1);
      pred(32'h104, 32'h10, 32'h114, 1'b1, "two_taken");
      pred(32'h108, 32'hFFFF_FFFC, 32'h104, 1'b0, "isolation");

      // Saturate high: 3 stays 3, then 3 -> 2 -> 1.
      for (int i = 0; i < 5; i++) upd(32'h104, 1'b1);
      upd(32'h104, 1'b0);
      pred(32'h104, 32'h0, 32'h104, 1'b1, "sat_hi_dec1");
      upd(32'h104, 1'b0);
      pred(32'h104, 32'h8, 32'h10C, 1'b0, "sat_hi_dec2");

      // Saturate low: 1 -> 0 and holds, then 0 -> 1 -> 2.
      for (int i = 0; i < 4; i++) upd(32'h104, 1'b0);
      upd(32'h104, 1'b1);
      pred(32'h104, 32'h0, 32'h104, 1'b0, "sat_lo_inc1");
      upd(32'h104, 1'b1);
      pred(32'h104, 32'h0, 32'h104, 1'b1, "sat_lo_inc2");

      // Target wraps mod 2^32; entry 63 still at reset value.
      pred(32'hFFFF_FFFC, 32'h8, 32'h4, 1'b0, "addr_wrap");

      // Read-before-write: entry 1 at 1, predict and taken update together.
      upd(32'h104, 1'b0);
      step(1'b1, 1'b1, 32'h104, 32'h0, 32'h104, 1'b0, "rbw_same", 1'b1, 32'h104, 1'b1);
      pred(32'h104, 32'h0, 32'h104, 1'b1, "rbw_next");

      // Entry 1 at 2; push it to 3, then reset alongside a taken update.
      upd(32'h104, 1'b1);
      step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "", 1'b1, 32'h104, 1'b1);
      pred(32'h104, 32'h0, 32'h104, 1'b0, "reset_drop");
      upd(32'h104, 1'b1);
      pred(32'h104, 32'h0, 32'h104, 1'b1, "post_reset_one_upd");

      // Aliasing: 0x004 and 0x104 share index 1; low PC bits ignored.
      step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "", 1'b0, 32'h0, 1'b0);
      upd(32'h004, 1'b1);
      upd(32'h004, 1'b1);
      pred(32'h104, 32'h4, 32'h108, 1'b1, "alias");
      pred(32'h107, 32'h1, 32'h108, 1'b1, "low_bits_ignored");
      pred(32'h204, 32'h0, 32'h204, 1'b1, "alias_high_bits");
      pred(32'h008, 32'h0, 32'h008, 1'b0, "alias_neighbour");

      idle();
      idle();
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
